seq_detector_param: RTL and testbench

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

---
 rtl/seq_det_pkg.sv | 14 +
 rtl/seq_detector_param_sat_counter.sv | 34 +++
 rtl/seq_detector_param.sv | 117 +++++++++++
 tb/tb_seq_detector_param.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and sizing helpers for the parameterised serial sequence detector.
package seq_det_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Width able to hold any count from 0 up to and including max_len.
  function automatic int fill_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial pattern detector with overlap control and a saturating match count.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] pat_len,
  input  logic                         overlap,
  input  logic                         in_valid,
  input  logic                         in_bit,
  input  logic                         clr_count,
  output logic                         detected,
  output logic [CNT_W-1:0]             match_count,
  output logic                         cfg_err,
  output logic                         armed
);

  localparam int FW = fill_width(MAX_LEN);

  state_t               state_q,   state_d;
  logic [MAX_LEN-1:0]   pattern_q, pattern_d;
  logic [FW-1:0]        pat_len_q, pat_len_d;
  logic                 overlap_q, overlap_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [MAX_LEN-1:0]   hist_q,    hist_d;
  logic [FW-1:0]        fill_q,    fill_d;
  logic                 detected_q;

  logic                 match;
  logic [FW-1:0]        fill_inc;
  logic [MAX_LEN-1:0]   hist_shift;
  logic [MAX_LEN-1:0]   mask;

  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    pat_len_d  = pat_len_q;
    overlap_d  = overlap_q;
    cfg_err_d  = cfg_err_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    match      = 1'b0;
    mask       = '0;
    fill_inc   = fill_q;
    hist_shift = {hist_q[MAX_LEN-2:0], in_bit};

    if (fill_q != FW'(MAX_LEN)) begin
      fill_inc = fill_q + FW'(1);
    end

    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(pat_len_q));
    end

    // A configuration load always wins: the same-cycle data bit is dropped.
    if (cfg_load) begin
      pattern_d = pattern;
      pat_len_d = pat_len;
      overlap_d = overlap;
      hist_d    = '0;
      fill_d    = '0;
      if ((pat_len != '0) && (pat_len <= FW'(MAX_LEN))) begin
        state_d   = RUN;
        cfg_err_d = 1'b0;
      end else begin
        state_d   = IDLE;
        cfg_err_d = 1'b1;
      end
    end else if ((state_q == RUN) && in_valid) begin
      hist_d = hist_shift;
      match  = (fill_inc >= pat_len_q) && (((hist_shift ^ pattern_q) & mask) == '0);
      fill_d = (match && !overlap_q) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pattern_q  <= '0;
      pat_len_q  <= '0;
      overlap_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
      hist_q     <= '0;
      fill_q     <= '0;
      detected_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      pat_len_q  <= pat_len_d;
      overlap_q  <= overlap_d;
      cfg_err_q  <= cfg_err_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      detected_q <= match;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_count (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_count),
    .inc   (match),
    .count (match_count)
  );

  assign detected = detected_q;
  assign cfg_err  = cfg_err_q;
  assign armed    = (state_q == RUN);

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed, table-driven bench for seq_detector_param (MAX_LEN=8, CNT_W=2 to reach saturation).
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;

  typedef struct {
    logic       load;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ov;
    logic       v;
    logic       b;
    logic       clr;
    logic       e_det;
    logic [1:0] e_cnt;
    logic       e_err;
    logic       e_arm;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_load;
  logic [7:0]       pattern;
  logic [3:0]       pat_len;
  logic             overlap;
  logic             in_valid;
  logic             in_bit;
  logic             clr_count;
  logic             detected;
  logic [CNT_W-1:0] match_count;
  logic             cfg_err;
  logic             armed;

  int tests_run    = 0;
  int tests_failed = 0;
  vec_t vecs[$];

  seq_detector_param #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_load   (cfg_load),
    .pattern    (pattern),
    .pat_len    (pat_len),
    .overlap    (overlap),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .clr_count  (clr_count),
    .detected   (detected),
    .match_count(match_count),
    .cfg_err    (cfg_err),
    .armed      (armed)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic load, input logic [7:0] pat, input logic [3:0] len,
                              input logic ov, input logic v, input logic b, input logic clr,
                              input logic e_det, input logic [1:0] e_cnt, input logic e_err,
                              input logic e_arm);
    vec_t r;
    r.load = load; r.pat = pat; r.len = len; r.ov = ov; r.v = v; r.b = b; r.clr = clr;
    r.e_det = e_det; r.e_cnt = e_cnt; r.e_err = e_err; r.e_arm = e_arm;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input vec_t v);
    checkOutput({tag, " detected"},    32'(detected),    32'(v.e_det));
    checkOutput({tag, " match_count"}, 32'(match_count), 32'(v.e_cnt));
    checkOutput({tag, " cfg_err"},     32'(cfg_err),     32'(v.e_err));
    checkOutput({tag, " armed"},       32'(armed),       32'(v.e_arm));
  endtask

  // Drive on the falling edge, let one rising edge act, then sample just after it.
  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    cfg_load  = v.load;
    pattern   = v.pat;
    pat_len   = v.len;
    overlap   = v.ov;
    in_valid  = v.v;
    in_bit    = v.b;
    clr_count = v.clr;
    @(posedge clk);
    #1;
    checkAll(tag, v);
  endtask

  task automatic stream(input logic b, input logic e_det, input logic [1:0] e_cnt,
                        input logic e_arm, input string tag);
    applyStimulus(mk(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b, 1'b0, e_det, e_cnt, 1'b0, e_arm), tag);
  endtask

  initial begin
    logic [7:0] a5;
    reset = 1'b1; cfg_load = 1'b0; pattern = '0; pat_len = '0; overlap = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; clr_count = 1'b0;

    // Overlapping 1101 over 1101101: pulses on bits 4 and 7.
    vecs.push_back(mk(1, 8'h0D, 4'd4, 1, 0, 0, 0, 0, 2'd0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 2'd0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 2'd0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 0, 0, 0, 2'd0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 1, 0, 1, 2'd1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 2'd1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 0, 0, 0, 2'd1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 1, 0, 1, 2'd2, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 0, 0, 1, 0, 2'd0, 0, 1));
    // Non-overlapping: only bit 4 matches.
    vecs.push_back(mk(1, 8'h0D, 4'd4, 0, 0, 0, 0, 0, 2'd0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 2'd0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 2'd0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 0, 0, 0, 2'd0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 1, 0, 1, 2'd1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 2'd1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 0, 0, 0, 2'd1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 2'd1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 0, 0, 1, 0, 2'd0, 0, 1));
    // 0xA5 with a garbage (inverted) bit on every invalid cycle.
    vecs.push_back(mk(1, 8'hA5, 4'd8, 0, 0, 0, 0, 0, 2'd0, 0, 1));
    a5 = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, a5[i], 0, (i == 0), (i == 0) ? 2'd1 : 2'd0, 0, 1));
      vecs.push_back(mk(0, 8'h00, 4'd0, 0, 0, ~a5[i], 0, 0, (i == 0) ? 2'd1 : 2'd0, 0, 1));
    end
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 0, 0, 1, 0, 2'd0, 0, 1));
    // Zero length is rejected and the stream is ignored.
    vecs.push_back(mk(1, 8'h0F, 4'd0, 1, 0, 0, 0, 0, 2'd0, 1, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 2'd0, 1, 0));
    // Length above MAX_LEN drops a running detector back to IDLE.
    vecs.push_back(mk(1, 8'h01, 4'd1, 1, 0, 0, 0, 0, 2'd0, 0, 1));
    vecs.push_back(mk(1, 8'h01, 4'd9, 1, 0, 0, 0, 0, 2'd0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 2'd0, 1, 0));
    // One-bit pattern saturates the 2-bit counter; clear beats a same-cycle match.
    vecs.push_back(mk(1, 8'h01, 4'd1, 1, 0, 0, 0, 0, 2'd0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 1, 0, 1, 2'd1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 1, 0, 1, 2'd2, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 1, 0, 1, 2'd3, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 1, 0, 1, 2'd3, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 1, 0, 1, 2'd3, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 0, 0, 1, 0, 2'd0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 1, 1, 1, 2'd0, 0, 1));
    // Load with in_valid high discards that bit.
    vecs.push_back(mk(1, 8'h01, 4'd1, 1, 1, 1, 0, 0, 2'd0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 1, 1, 0, 1, 2'd1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0, 0, 0, 0, 1, 0, 2'd0, 0, 1));

    repeat (2) @(posedge clk);
    #1;
    checkAll("reset", mk(0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Mid-stream reset discards partial history and requires a fresh load.
    applyStimulus(mk(1, 8'h0D, 4'd4, 1, 0, 0, 0, 0, 2'd0, 0, 1), "rst load");
    stream(1, 0, 2'd0, 1, "rst a1");
    stream(1, 0, 2'd0, 1, "rst a2");
    stream(0, 0, 2'd0, 1, "rst a3");
    stream(1, 1, 2'd1, 1, "rst a4");
    stream(1, 0, 2'd1, 1, "rst b1");
    stream(1, 0, 2'd1, 1, "rst b2");
    stream(0, 0, 2'd1, 1, "rst b3");
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkAll("rst async", mk(0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    stream(1, 0, 2'd0, 0, "post-rst unloaded");
    applyStimulus(mk(1, 8'h0D, 4'd4, 1, 0, 0, 0, 0, 2'd0, 0, 1), "post-rst load");
    stream(1, 0, 2'd0, 1, "post-rst c0");
    stream(1, 0, 2'd0, 1, "post-rst c1");
    stream(1, 0, 2'd0, 1, "post-rst c2");
    stream(0, 0, 2'd0, 1, "post-rst c3");
    stream(1, 1, 2'd1, 1, "post-rst c4");
    stream(1, 0, 2'd1, 1, "post-rst c5");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
